// File: rtl/game_tick_scheduler.sv
// Frame/tick scheduler: a prescaler derives the base frame pulse from the system clock,
// and NUM_CH programmable dividers derive slower per-channel ticks from that pulse.
module game_tick_scheduler #(
   parameter int PRESCALE       = 833333,
   parameter int PRE_W          = 20,
   parameter int NUM_CH         = 4,
   parameter int SEL_W          = 2,
   parameter int PERIOD_W       = 8,
   parameter int DEFAULT_PERIOD = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                pause,
   input  logic                step,
   input  logic                period_wr,
   input  logic [SEL_W-1:0]    period_sel,
   input  logic [PERIOD_W-1:0] period_data,
   output logic                frame_tick,
   output logic [NUM_CH-1:0]   ch_tick,
   output logic [15:0]         frame_count
);

   localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [PERIOD_W-1:0] PER_RST  = PERIOD_W'(DEFAULT_PERIOD);

   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [PERIOD_W-1:0] period_q [NUM_CH];
   logic [PERIOD_W-1:0] period_d [NUM_CH];
   logic [PERIOD_W-1:0] cnt_q [NUM_CH];
   logic [PERIOD_W-1:0] cnt_d [NUM_CH];
   logic                frame_tick_q, frame_tick_d;
   logic [NUM_CH-1:0]   ch_tick_q, ch_tick_d;
   logic [15:0]         frame_count_q, frame_count_d;
   logic                pre_wrap;
   logic                fp;
   logic [NUM_CH-1:0]   wr_hit;

   // While paused the frame pulse comes only from step; the prescaler just holds.
   always_comb begin
      pre_wrap = (pre_q == PRE_LAST);
      fp       = enable && (pause ? step : pre_wrap);
      pre_d    = pre_q;
      if (!enable) begin
         pre_d = '0;
      end else if (!pause) begin
         pre_d = pre_wrap ? '0 : pre_q + PRE_W'(1);
      end
   end

   // Out-of-range selects match no channel, so such writes fall away.
   always_comb begin
      wr_hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_hit[i] = period_wr && (period_sel == SEL_W'(i));
      end
   end

   // A write beats a coincident frame for its own channel: counter cleared, tick dropped.
   always_comb begin
      period_d  = period_q;
      cnt_d     = cnt_q;
      ch_tick_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (wr_hit[i]) begin
            period_d[i] = period_data;
            cnt_d[i]    = '0;
         end else if (!enable) begin
            cnt_d[i] = '0;
         end else if (fp && (period_q[i] != '0)) begin
            if (cnt_q[i] == period_q[i] - PERIOD_W'(1)) begin
               cnt_d[i]     = '0;
               ch_tick_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
            end
         end
      end
   end

   always_comb begin
      frame_tick_d  = fp;
      frame_count_d = frame_count_q + {15'd0, fp};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pre_q         <= '0;
         frame_tick_q  <= 1'b0;
         ch_tick_q     <= '0;
         frame_count_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            period_q[i] <= PER_RST;
            cnt_q[i]    <= '0;
         end
      end else begin
         pre_q         <= pre_d;
         frame_tick_q  <= frame_tick_d;
         ch_tick_q     <= ch_tick_d;
         frame_count_q <= frame_count_d;
         for (int i = 0; i < NUM_CH; i++) begin
            period_q[i] <= period_d[i];
            cnt_q[i]    <= cnt_d[i];
         end
      end
   end

   assign frame_tick  = frame_tick_q;
   assign ch_tick     = ch_tick_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler with PRESCALE=4, NUM_CH=4: the driver pushes expected
// frames (edge number, ch_tick, frame_count) and a negedge monitor pops and compares.
module tb_game_tick_scheduler;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       pause;
   logic       step;
   logic       period_wr;
   logic [1:0] period_sel;
   logic [7:0] period_data;
   logic       frame_tick;
   logic [3:0] ch_tick;
   logic [15:0] frame_count;

   game_tick_scheduler #(
      .PRESCALE(4), .PRE_W(3), .NUM_CH(4), .SEL_W(2), .PERIOD_W(8), .DEFAULT_PERIOD(1)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .pause(pause), .step(step),
      .period_wr(period_wr), .period_sel(period_sel), .period_data(period_data),
      .frame_tick(frame_tick), .ch_tick(ch_tick), .frame_count(frame_count)
   );

   // clock / reset block
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // scoreboard: {edge number, ch_tick, frame_count}
   logic [51:0] exp_q[$];

   // frame-level reference: frames since last counter clear per channel
   logic [7:0]  m_per [4];
   int          m_since [4];
   logic [15:0] m_fc;
   int          next_fe;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         m_per[i]   = 8'd1;
         m_since[i] = 0;
      end
      m_fc = 16'd0;
   endfunction

   function automatic void model_frame(input logic [3:0] skip, input int e);
      logic [3:0] t;
      t = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if (!skip[i]) begin
            m_since[i]++;
            if ((m_per[i] != 8'd0) && ((m_since[i] % int'(m_per[i])) == 0)) t[i] = 1'b1;
         end
      end
      m_fc = m_fc + 16'd1;
      exp_q.push_back({32'(e), t, m_fc});
   endfunction

   // driver tasks; all start and end 1 time unit after a rising edge
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic wait_to(input int e);
      while (cyc < e) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic run_frames(input int k);
      for (int j = 0; j < k; j++) begin
         model_frame(4'b0000, next_fe);
         next_fe += 4;
      end
      wait_to(next_fe - 4);
   endtask

   task automatic do_write(input logic [1:0] s, input logic [7:0] d);
      period_wr   = 1'b1;
      period_sel  = s;
      period_data = d;
      m_per[s]    = d;
      m_since[s]  = 0;
      tick(1);
      period_wr = 1'b0;
   endtask

   // monitor
   always @(negedge clock) begin
      if (!reset) begin
         if (frame_tick) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_frame_tick", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
               logic [51:0] e;
               e = exp_q.pop_front();
               chk("frame_edge", 32'(cyc), e[51:20]);
               chk("ch_tick", {28'd0, ch_tick}, {28'd0, e[19:16]});
               chk("frame_count", {16'd0, frame_count}, {16'd0, e[15:0]});
            end
         end else begin
            chk("ch_tick_idle", {28'd0, ch_tick}, 32'd0);
         end
      end
   end

   task automatic report();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
   endtask

   initial begin
      #1500000;
      n_fail++;
      $display("FAIL watchdog: simulation time exceeded at cycle %0d", cyc);
      report();
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      reset = 1'b1; enable = 1'b0; pause = 1'b0; step = 1'b0;
      period_wr = 1'b0; period_sel = 2'd0; period_data = 8'd0;
      model_reset();
      @(posedge clock);
      #1;
      tick(2);
      chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
      chk("rst_ch_tick", {28'd0, ch_tick}, 32'd0);
      chk("rst_frame_count", {16'd0, frame_count}, 32'd0);

      // all channels at period 1 tick with every frame, frames every 4 clocks
      reset = 1'b0; enable = 1'b1;
      next_fe = cyc + 4;
      run_frames(3);

      // ch1 every 3rd frame, ch2 disabled; a step while running is ignored
      do_write(2'd1, 8'd3);
      do_write(2'd2, 8'd0);
      step = 1'b1;
      tick(1);
      step = 1'b0;
      run_frames(7);

      // pause mid-frame, single step, resume from the held prescaler value
      tick(2);
      pause = 1'b1;
      tick(20);
      chk("pause_hold_fc", {16'd0, frame_count}, {16'd0, m_fc});
      step = 1'b1;
      model_frame(4'b0000, cyc + 1);
      tick(1);
      step = 1'b0;
      tick(3);
      chk("step_fc", {16'd0, frame_count}, {16'd0, m_fc});
      pause = 1'b0;
      next_fe = cyc + 2;
      run_frames(2);

      // period write coinciding with the frame pulse suppresses that channel's tick
      wait_to(next_fe - 1);
      period_wr = 1'b1; period_sel = 2'd1; period_data = 8'd2;
      model_frame(4'b0010, next_fe);
      m_per[1] = 8'd2;
      m_since[1] = 0;
      tick(1);
      period_wr = 1'b0;
      next_fe += 4;
      run_frames(4);

      // fast-forward with continuous steps across the 16-bit wrap
      pause = 1'b1;
      k = 65538 - int'(m_fc);
      step = 1'b1;
      for (int j = 0; j < k; j++) begin
         model_frame(4'b0000, cyc + 1);
         tick(1);
      end
      step = 1'b0;
      tick(1);
      chk("wrap_fc", {16'd0, frame_count}, 32'h0000_0002);

      // resume, then drop enable for 3 cycles mid-frame (step ignored meanwhile)
      pause = 1'b0;
      tick(2);
      enable = 1'b0;
      for (int i = 0; i < 4; i++) m_since[i] = 0;
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(2);
      chk("disable_fc_hold", {16'd0, frame_count}, 32'h0000_0002);
      enable = 1'b1;
      next_fe = cyc + 4;
      run_frames(4);

      // async reset in the middle of a frame_tick pulse
      wait_to(next_fe);
      chk("pulse_before_reset", {31'd0, frame_tick}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("async_frame_tick", {31'd0, frame_tick}, 32'd0);
      chk("async_ch_tick", {28'd0, ch_tick}, 32'd0);
      chk("async_frame_count", {16'd0, frame_count}, 32'd0);
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b0;
      next_fe = cyc + 4;
      run_frames(3);
      tick(2);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      report();
      $finish;
   end

endmodule
